// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified IF/MEM memory arbiter and the memory models
// that stand in for DataMem/InstructionMem.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } arb_state_e;

    localparam logic G_IF  = 1'b0;
    localparam logic G_MEM = 1'b1;

    localparam int unsigned RD_LAT_DEF     = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// Read-latency down-counter: loads on issue, decrements while the arbiter waits on memory.
module arb_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF,
    localparam int unsigned CNT_W = $clog2(RD_LAT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and load/store,
// sequences the fixed read latency and produces the per-stage stall signals.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = RD_LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STARVE_SAT = STV_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(RD_LAT - 1);

    arb_state_e       state_q, state_d;
    logic             grant_q;
    logic             we_q;
    logic             drop_q;
    logic [STV_W-1:0] starve_q;
    logic [CNT_W-1:0] lat_cnt;
    logic             lat_zero;

    logic any_req;
    logic if_wins;
    logic issue;
    logic issue_grant;
    logic issue_we;

    // MEM is the older instruction and wins unless IF has been starved long enough.
    assign any_req     = if_req | mem_req;
    assign if_wins     = if_req & (~mem_req | (starve_q == STARVE_SAT));
    assign issue_grant = if_wins ? G_IF : G_MEM;
    assign issue_we    = ~if_wins & mem_we;
    assign issue       = reset & (state_q == StIdle) & any_req;

    arb_lat_counter #(
        .RD_LAT (RD_LAT)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (issue & ~issue_we),
        .dec      (state_q == StWait),
        .load_val (LAT_LOAD),
        .count    (lat_cnt),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = (issue_we || (RD_LAT == 1)) ? StResp : StWait;
                end
            end
            StWait: begin
                // The count reaches zero on this edge, so the response is next cycle.
                if (lat_zero || (lat_cnt == CNT_W'(1))) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_en      = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        if_rdata  = '0;
        mem_rdata = '0;
        if (reset) begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        m_en = 1'b1;
                        if (if_wins) begin
                            m_addr = if_addr;
                        end else begin
                            m_we    = mem_we;
                            m_addr  = mem_addr;
                            m_wdata = mem_wdata;
                        end
                    end
                end
                StResp: begin
                    if (grant_q == G_IF) begin
                        if_ready = ~drop_q & ~if_flush;
                        if (if_ready) begin
                            if_rdata = m_rdata;
                        end
                    end else begin
                        mem_ready = 1'b1;
                        if (!we_q) begin
                            mem_rdata = m_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_stall  = if_req & ~if_ready;
    assign mem_stall = mem_req & ~mem_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_q <= G_IF;
            we_q    <= 1'b0;
        end else if (issue) begin
            grant_q <= issue_grant;
            we_q    <= issue_we;
        end
    end

    // A redirected fetch still occupies the memory; only its completion pulse is hidden.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_q <= 1'b0;
        end else if (issue) begin
            drop_q <= if_wins & if_flush;
        end else if (state_q == StResp) begin
            drop_q <= 1'b0;
        end else if ((state_q == StWait) && (grant_q == G_IF) && if_flush) begin
            drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else if ((state_q == StIdle) && !if_req) begin
            starve_q <= '0;
        end else if (issue && if_wins) begin
            starve_q <= '0;
        end else if (issue && if_req && (starve_q != STARVE_SAT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline. The block grants one access at a time, sequences the memory's latency, routes read data back to the requester, and generates per-stage stall signals. These stalls feed the hazard unit's PC/IF-ID write enables and the pipeline-register holds.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
RD_LAT, 2, memory read latency in cycles (>=1); read data is valid RD_LAT cycles after the issue cycle
STARVE_MAX, 4, consecutive MEM grants allowed while IF waits before IF is forced to win (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request; held by IF until if_ready or if_flush
if_addr  in  ADDR_W  fetch address
if_flush  in  1  drop the outstanding fetch (branch/jump redirect)
if_rdata  out  DATA_W  instruction; valid only when if_ready=1
if_ready  out  1  one-cycle completion pulse for IF
if_stall  out  1  if_req & ~if_ready
mem_req  in  1  data request; held until mem_ready
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data; valid only when mem_ready=1
mem_ready  out  1  one-cycle completion pulse for MEM
mem_stall  out  1  mem_req & ~mem_ready
m_en  out  1  memory access strobe, one cycle per access
m_we  out  1  memory write enable, qualified by m_en
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (reset=0 at a clock edge): FSM returns to IDLE. Starvation counter, latency counter, grant and drop flag clear. All registered outputs go to 0. An in-flight memory response is ignored. Reset takes precedence over every other input.
- FSM states: IDLE, WAIT, RESP. Grant encoding: G_IF, G_MEM.
- IDLE: with no request, m_en=0 and the FSM stays in IDLE. With any request, it arbitrates combinationally, drives m_en=1 with the winner's m_addr/m_we/m_wdata (IF: m_we=0, m_wdata=0), and latches the grant. This is issue cycle t.
  - Read: latency counter loads RD_LAT-1. If RD_LAT=1, next state is RESP; otherwise WAIT.
  - Write: next state is RESP, so the store completes at t+1.
- WAIT: the counter decrements each cycle. When it reaches 0, the next state is RESP. m_en=0 throughout.
- RESP: asserts the granted port's ready for exactly one cycle. Read data passes through combinationally: rdata = m_rdata. The non-granted ready stays 0. Next state is IDLE.
  - Read ready occurs at cycle t+RD_LAT.
  - The earliest next issue is the cycle after RESP.
- rdata outputs are 0 whenever the corresponding ready=0.
- Arbitration: MEM has priority, as the older instruction.
  - The starvation counter increments on each MEM grant issued while if_req=1.
  - The counter clears on an IF grant, or in any IDLE cycle with if_req=0.
  - When the counter equals STARVE_MAX and both requests are present, IF wins.
  - The counter saturates at STARVE_MAX.
- if_flush:
  - Asserted while an IF access is in WAIT or RESP (including the RESP cycle itself): sets a drop flag, so if_ready stays 0 for that access. The memory cycle still completes and the FSM timing is unchanged.
  - In IDLE or during a MEM access: no effect.
  - Asserted in the issue cycle of an IF access: the issue proceeds and the response is dropped.
- The drop flag clears on entry to IDLE.
- The requester must hold address and data stable from req until ready. The arbiter samples them only in the issue cycle.
- If a request is still held the cycle after its ready, it is treated as a new access.
- Address values are opaque: no alignment checking, no width conversion.

Decomposition:
- Shared package (mem_arb_pkg):
  - FSM state enum: IDLE, WAIT, RESP.
  - Grant constants: G_IF, G_MEM.
  - Default RD_LAT and STARVE_MAX constants, also used by the DataMem/InstructionMem replacement model.
- One sub-module: arb_lat_counter. It is a down-counter with load/decrement and zero flag, sized $clog2(RD_LAT+1), and is used for the WAIT sequencing.
- The starvation counter stays inline.

Test Plan:
- Reset then single IF read: RD_LAT=2, if_req=1 with if_addr=0x0000_0040 at t. Required: m_en=1, m_addr=0x40 at t; if_stall=1 at t and t+1; if_ready=1 with if_rdata=m_rdata at t+2; if_stall=0 at t+2.
- Simultaneous requests: mem load 0x100 and IF fetch 0x44 both at t. Required: MEM issued at t, mem_ready at t+2; IF issued at t+3, if_ready at t+5.
- Store: mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF. Required: m_en=m_we=1 with those values at t; mem_ready at t+1; mem_rdata=0.
- Starvation: STARVE_MAX=4, mem_req and if_req held continuously. Required: exactly 4 MEM grants, then an IF grant, then MEM resumes.
- Flush: IF fetch issued at t, if_flush=1 at t+1. Required: if_ready stays 0 at t+2; the FSM reaches IDLE at t+3, and a new fetch of 0x80 issues at t+3.
- Reset mid-access: reset=0 at t+1 of a load. Required: all ready signals 0; m_en=0; the FSM is in IDLE after the edge; no stale response once reset is released.
